stage4_memory: RTL and testbench
================================

Name: stage4_memory

Overview:
- Memory-access stage, directly downstream of the execution stage.
- Consumes the ALU result (effective address) and the forwarded store data, and runs a req/gnt/rvalid transaction on the data-memory port.
- Aligns and extends load data, and flags misaligned or faulted accesses.
- Holds the pipeline through mem_stall_o until the access retires.

Parameters:
- XLEN, 32, datapath and address width. The design is 32-bit only; byte-lane logic assumes 4 lanes.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  kill the in-flight access (trap/redirect).
- ex_valid_i  input  1  EX result valid this cycle.
- rd_en_i  input  1  load.
- wr_en_i  input  1  store. Never asserted together with rd_en_i.
- size_i  input  2  00 byte, 01 half, 10 word. 11 is treated as word.
- unsigned_i  input  1  zero-extend the load (LBU/LHU).
- exc_i  input  1  upstream exception pending; suppresses the access.
- addr_i  input  XLEN  effective address (EX alu_result_o).
- wdata_i  input  XLEN  store data (EX write_data_o).
- dmem_req_o  output  1  bus request.
- dmem_we_o  output  1  write.
- dmem_addr_o  output  XLEN  word-aligned address; bits [1:0] are 0.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  XLEN  lane-replicated store data.
- dmem_gnt_i  input  1  request accepted.
- dmem_rvalid_i  input  1  response (load data or write ack).
- dmem_err_i  input  1  bus error; qualified by rvalid.
- dmem_rdata_i  input  XLEN  raw word.
- rdata_o  output  XLEN  aligned, extended load data.
- done_o  output  1  one-cycle pulse when an access retires.
- mem_stall_o  output  1  freeze upstream stages.
- load_misalign_o  output  1  misaligned load detected.
- store_misalign_o  output  1  misaligned store detected.
- access_fault_o  output  1  bus error on the retired access.

Behaviour:
- Access condition: acc = ex_valid_i & (rd_en_i | wr_en_i) & ~exc_i & ~flush_i.
- Alignment: a half-word access is misaligned if addr[0]=1. A word access is misaligned if addr[1:0]!=0. Byte accesses are always aligned.
- Misaligned access, in IDLE:
  - load_misalign_o or store_misalign_o is asserted combinationally for that cycle.
  - No bus request is made, mem_stall_o=0, and the FSM stays in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if acc and aligned:
    - register addr[XLEN-1:2]<<2, we, be, wdata, size, unsigned, addr[1:0];
    - mem_stall_o=1 combinationally;
    - next state REQ.
  - REQ: dmem_req_o=1 and mem_stall_o=1. Address, we, be and wdata stay stable until the cycle dmem_gnt_i=1, then go to WAIT.
  - WAIT: mem_stall_o=1. When dmem_rvalid_i=1:
    - capture the formatted load data into the rdata register (loads only; stores leave it unchanged);
    - capture dmem_err_i into the fault register;
    - go to DONE.
  - DONE: mem_stall_o=0, done_o=1, access_fault_o = fault register. Next state is IDLE. A new acc in DONE is not accepted until IDLE.
- Minimum latency with gnt and rvalid each arriving on the first possible cycle:
  - accept in cycle 0;
  - req+gnt in cycle 1;
  - rvalid in cycle 2;
  - done in cycle 3;
  - stall is asserted for cycles 0-2.
- Byte enables and store data:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{wdata_i[7:0]}};
  - half: be = 4'b0011 << {addr[1],1'b0}, wdata = {2{wdata_i[15:0]}};
  - word: be = 4'b1111, wdata = wdata_i.
  - For loads, dmem_be_o carries the same pattern.
- Load format: select the lane by the registered addr[1:0], then sign-extend, or zero-extend if unsigned.
- rdata_o holds its last value outside DONE.
- Flush:
  - in REQ before gnt: dmem_req_o drops next cycle, state goes to IDLE, no done_o;
  - in REQ on the gnt cycle, or in WAIT: set a drop flag and continue to wait for rvalid (the response must be consumed); on rvalid return to IDLE with no done_o, no fault, and rdata unchanged;
  - in IDLE: no access starts.
- rvalid outside WAIT is ignored.
- Reset: state=IDLE, all registers 0. Every output is 0, including dmem_req_o and rdata_o. Reset is honoured mid-transaction; a late rvalid after reset is ignored.

Test Plan:
- LW addr 0x100, gnt on the first REQ cycle, rvalid next with rdata 0xDEADBEEF → dmem_addr 0x100, be 1111; stall for 3 cycles; done_o in cycle 3; rdata_o 0xDEADBEEF.
- LB addr 0x203, rdata 0x80123456 → be 1000, rdata_o 0xFFFFFF80. The same access as LBU → 0x00000080.
- SH addr 0x302, wdata 0x1234ABCD → dmem_we 1, be 1100, dmem_wdata 0xABCDABCD, addr 0x300; done_o after the ack; rdata_o unchanged.
- LH addr 0x401 → load_misalign_o=1 in the same cycle; dmem_req_o never rises; stall 0. SW addr 0x402 → store_misalign_o=1.
- gnt held low for 3 REQ cycles → req, addr, be and wdata stable throughout; stall held. Inject flush_i in WAIT, then rvalid → no done_o, return to IDLE.
- LW with rvalid+err=1 → done_o=1 and access_fault_o=1 for one cycle. Assert rst_i during REQ → req drops and state is IDLE the next cycle.

Source files
------------

// File: rtl/stage4_memory.sv
// Memory-access stage: turns an EX result into one req/gnt/rvalid transaction on
// the data-memory port, formats load data and reports misalignment and bus faults.
module stage4_memory #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            ex_valid_i,
  input  logic            rd_en_i,
  input  logic            wr_en_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic            exc_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic            dmem_err_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            done_o,
  output logic            mem_stall_o,
  output logic            load_misalign_o,
  output logic            store_misalign_o,
  output logic            access_fault_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: the request is held (dmem_req_o with stable addr/we/be/wdata) until
  // the cycle dmem_gnt_i=1; exactly one dmem_rvalid_i is then consumed per grant.

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   rdata_q;
  logic              fault_q;
  logic              drop_q, drop_d;

  logic              acc;
  logic              misaligned;
  logic              start;
  logic              capture;
  logic [3:0]        be_new;
  logic [XLEN-1:0]   wdata_new;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_fmt;

  assign acc   = ex_valid_i & (rd_en_i | wr_en_i) & ~exc_i & ~flush_i & ~rst_i;
  assign start = (state_q == S_IDLE) & acc & ~misaligned;

  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = wdata_i;
    case (size_i)
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = addr_i[0];
        be_new     = 4'b0011 << {addr_i[1], 1'b0};
        wdata_new  = {2{wdata_i[15:0]}};
      end
      default: misaligned = |addr_i[1:0];
    endcase
  end

  // The lane offset is zero for words and even for halves, so one shifter serves all sizes.
  assign shifted = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_fmt = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_fmt = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          state_d = S_WAIT;
          drop_d  = flush_i;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          drop_d = 1'b0;
          if (drop_q | flush_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            capture = 1'b1;
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (start) begin
        addr_q  <= {addr_i[XLEN-1:2], 2'b00};
        we_q    <= wr_en_i;
        be_q    <= be_new;
        wdata_q <= wdata_new;
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        off_q   <= addr_i[1:0];
      end
      if (capture) begin
        fault_q <= dmem_err_i;
        if (!we_q) rdata_q <= load_fmt;
      end
    end
  end

  assign dmem_req_o       = (state_q == S_REQ);
  assign dmem_we_o        = we_q;
  assign dmem_addr_o      = addr_q;
  assign dmem_be_o        = be_q;
  assign dmem_wdata_o     = wdata_q;
  assign rdata_o          = rdata_q;
  assign done_o           = (state_q == S_DONE);
  assign access_fault_o   = (state_q == S_DONE) & fault_q;
  assign mem_stall_o      = start | (state_q == S_REQ) | (state_q == S_WAIT);
  assign load_misalign_o  = (state_q == S_IDLE) & acc & misaligned & rd_en_i;
  assign store_misalign_o = (state_q == S_IDLE) & acc & misaligned & wr_en_i;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_stage4_memory.sv
// Directed bench for stage4_memory: inputs change 1 time unit after the rising
// edge, outputs are checked 1 unit later with immediate assertions.
module tb_stage4_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, ex_valid, rd_en, wr_en, uns, exc;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        req, we, gnt, rvalid, err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, rdata;
  logic [3:0]  be;
  logic        done, stall, lmis, smis, fault;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;

  always #5 clk = ~clk;

  stage4_memory dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_valid_i(ex_valid),
    .rd_en_i(rd_en), .wr_en_i(wr_en), .size_i(size), .unsigned_i(uns),
    .exc_i(exc), .addr_i(addr), .wdata_i(wdata),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(dmem_addr), .dmem_be_o(be),
    .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_err_i(err), .dmem_rdata_i(dmem_rdata), .rdata_o(rdata),
    .done_o(done), .mem_stall_o(stall), .load_misalign_o(lmis),
    .store_misalign_o(smis), .access_fault_o(fault), .dbg_state_o(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; rd_en = ld; wr_en = st; size = sz; uns = u; addr = a; wdata = d;
  endtask

  task automatic quiet();
    ex_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Accepts an aligned access, grants in the first REQ cycle, responds next cycle,
  // and leaves the bench sitting in the DONE cycle.
  task automatic simple_access(input logic ld, input logic st, input logic [1:0] sz,
                               input logic u, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] resp, input logic e);
    issue(ld, st, sz, u, a, d);
    tick();
    quiet();
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; dmem_rdata = resp; err = e;
    tick();
    rvalid = 1'b0; err = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; exc = 1'b0; uns = 1'b0; size = 2'b10;
    addr = '0; wdata = '0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; dmem_rdata = '0;
    quiet();
    tick();
    tick();
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_addr", dmem_addr, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b0;
    tick();

    // LW 0x100, minimum latency
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    settle();
    chk("lw_c0_stall", {31'd0, stall}, 32'd1);
    chk("lw_c0_req", {31'd0, req}, 32'd0);
    tick();
    quiet(); gnt = 1'b1;
    settle();
    chk("lw_c1_req", {31'd0, req}, 32'd1);
    chk("lw_c1_addr", dmem_addr, 32'h100);
    chk("lw_c1_be", {28'd0, be}, 32'hF);
    chk("lw_c1_we", {31'd0, we}, 32'd0);
    chk("lw_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    gnt = 1'b0; rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    settle();
    chk("lw_c2_stall", {31'd0, stall}, 32'd1);
    chk("lw_c2_req", {31'd0, req}, 32'd0);
    chk("lw_c2_done", {31'd0, done}, 32'd0);
    tick();
    rvalid = 1'b0;
    settle();
    chk("lw_c3_done", {31'd0, done}, 32'd1);
    chk("lw_c3_stall", {31'd0, stall}, 32'd0);
    chk("lw_c3_rdata", rdata, 32'hDEADBEEF);
    chk("lw_c3_fault", {31'd0, fault}, 32'd0);
    tick();
    chk("lw_c4_done", {31'd0, done}, 32'd0);
    chk("lw_c4_rdata_hold", rdata, 32'hDEADBEEF);

    // LB / LBU 0x203
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
    tick();
    quiet(); gnt = 1'b1;
    settle();
    chk("lb_be", {28'd0, be}, 32'h8);
    chk("lb_addr", dmem_addr, 32'h200);
    tick();
    gnt = 1'b0; rvalid = 1'b1; dmem_rdata = 32'h80123456;
    tick();
    rvalid = 1'b0;
    settle();
    chk("lb_done", {31'd0, done}, 32'd1);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    tick();
    simple_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80123456, 1'b0);
    chk("lbu_rdata", rdata, 32'h00000080);
    tick();

    // LH 0x202 upper half, sign-extended
    simple_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h80123456, 1'b0);
    chk("lh_rdata", rdata, 32'hFFFF8012);
    tick();
    simple_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80123456, 1'b0);
    tick();

    // SH 0x302
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h1234ABCD);
    tick();
    quiet(); gnt = 1'b1;
    settle();
    chk("sh_we", {31'd0, we}, 32'd1);
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h300);
    tick();
    gnt = 1'b0; rvalid = 1'b1; dmem_rdata = 32'h55555555;
    tick();
    rvalid = 1'b0;
    settle();
    chk("sh_done", {31'd0, done}, 32'd1);
    chk("sh_rdata_kept", rdata, 32'h00000080);
    tick();

    // SB 0x001 lane replication
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h000000A5);
    tick();
    quiet();
    settle();
    chk("sb_be", {28'd0, be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    gnt = 1'b1; tick(); gnt = 1'b0; rvalid = 1'b1; tick(); rvalid = 1'b0; tick();

    // Misaligned LH 0x401 and SW 0x402
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h401, 32'h0);
    settle();
    chk("lh_mis_flag", {31'd0, lmis}, 32'd1);
    chk("lh_mis_stall", {31'd0, stall}, 32'd0);
    chk("lh_mis_sflag", {31'd0, smis}, 32'd0);
    tick();
    quiet();
    settle();
    chk("lh_mis_req", {31'd0, req}, 32'd0);
    chk("lh_mis_state", {30'd0, dbg_state}, {30'd0, IDLE});
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h402, 32'h0);
    settle();
    chk("sw_mis_flag", {31'd0, smis}, 32'd1);
    chk("sw_mis_lflag", {31'd0, lmis}, 32'd0);
    chk("sw_mis_stall", {31'd0, stall}, 32'd0);
    tick();
    quiet();
    settle();
    chk("sw_mis_req", {31'd0, req}, 32'd0);

    // Exception suppresses the access
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    exc = 1'b1;
    settle();
    chk("exc_stall", {31'd0, stall}, 32'd0);
    tick();
    quiet(); exc = 1'b0;
    settle();
    chk("exc_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // SW 0x500 with gnt held low for 3 REQ cycles
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'hCAFEF00D);
    tick();
    quiet(); wdata = 32'h0BADBEEF; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wt_req", {31'd0, req}, 32'd1);
      chk("wt_addr", dmem_addr, 32'h500);
      chk("wt_be", {28'd0, be}, 32'hF);
      chk("wt_wdata", dmem_wdata, 32'hCAFEF00D);
      chk("wt_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    gnt = 1'b1;
    settle();
    chk("wt_gnt_req", {31'd0, req}, 32'd1);
    tick();
    gnt = 1'b0; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    settle();
    chk("wt_done", {31'd0, done}, 32'd1);
    tick();

    // LW 0x600 flushed in WAIT
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
    tick();
    quiet(); gnt = 1'b1;
    tick();
    gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("fw_state", {30'd0, dbg_state}, {30'd0, WAIT});
    chk("fw_stall", {31'd0, stall}, 32'd1);
    rvalid = 1'b1; dmem_rdata = 32'h11111111; err = 1'b1;
    tick();
    rvalid = 1'b0; err = 1'b0;
    settle();
    chk("fw_done", {31'd0, done}, 32'd0);
    chk("fw_fault", {31'd0, fault}, 32'd0);
    chk("fw_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("fw_rdata_kept", rdata, 32'h00000080);
    tick();

    // LW flushed in REQ before gnt
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h640, 32'h0);
    tick();
    quiet(); flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("fr_req", {31'd0, req}, 32'd0);
    chk("fr_state", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("fr_done", {31'd0, done}, 32'd0);
    tick();

    // LW with bus error
    simple_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h680, 32'h0, 32'h22222222, 1'b1);
    chk("err_done", {31'd0, done}, 32'd1);
    chk("err_fault", {31'd0, fault}, 32'd1);
    tick();
    chk("err_fault_clear", {31'd0, fault}, 32'd0);

    // Reset during REQ, then a late rvalid
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h700, 32'h0);
    tick();
    quiet();
    settle();
    chk("rst_pre_req", {31'd0, req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("rst_rdata", rdata, 32'd0);
    rvalid = 1'b1; dmem_rdata = 32'h33333333;
    tick();
    rvalid = 1'b0;
    settle();
    chk("late_rvalid_done", {31'd0, done}, 32'd0);
    chk("late_rvalid_state", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("late_rvalid_rdata", rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
